csr_access_unit: RTL and testbench
==================================

CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

Interface
REQ-001 SHALL have ports: clk  input  1  clock; reset  input  1  synchronous active-high reset.
REQ-002 SHALL have request ports: req_valid  input  1  op present; req_ready  output  1  unit can accept; req_funct3  input  3  Zicsr funct3; req_csr  input  12  CSR address; req_rs1idx  input  5  rs1 index / zimm; req_rs1val  input  32  rs1 value.
REQ-003 SHALL have response ports: resp_valid  output  1  result ready; resp_ready  input  1  consumer accepts; resp_rdata  output  32  old CSR value; resp_illegal  output  1  op rejected.
REQ-004 SHALL have register-file ports: csr_raddr  output  6  read index; csr_rdata  input  32  combinational read data; csr_we  output  1  write strobe; csr_waddr  output  6  write index; csr_wdata  output  32  write data.
REQ-005 Register-file index SHALL be req_csr[5:0]; req_csr[11:6] SHALL be ignored except by REQ-020.

Function
REQ-006 FSM states SHALL be IDLE, READ, WRITE, RESP; all outputs registered or decoded from state only.
REQ-007 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready; IDLE->READ on handshake, capturing funct3, index, rs1idx, rs1val.
REQ-008 READ SHALL drive csr_raddr = captured index, capture csr_rdata into old register, go to WRITE (one cycle).
REQ-009 Operand SHALL be rs1val when funct3[2]=0, else zero-extended rs1idx (zimm).
REQ-010 New value: funct3[1:0]=01 operand; 10 old|operand; 11 old&~operand.
REQ-011 csr_we SHALL pulse exactly one cycle in WRITE, with csr_waddr = index, csr_wdata = new value, unless suppressed.
REQ-012 Write SHALL be suppressed for funct3[1:0] in {10,11} when rs1idx=0 (covers rs1=x0 and zimm=0); CSRRW/CSRRWI SHALL always write.
REQ-013 funct3 in {000,100} SHALL be illegal: no write, resp_illegal=1, resp_rdata=0.
REQ-014 WRITE->RESP unconditionally; RESP SHALL hold resp_valid=1 with stable resp_rdata/resp_illegal until resp_ready=1, then ->IDLE.
REQ-015 Latency: handshake in cycle N -> csr_we in N+2 -> resp_valid from N+3; throughput one op per 4 cycles when resp_ready held 1.
REQ-016 resp_rdata SHALL be the pre-write value (value read in READ), including when index read equals index written.
REQ-017 csr_we SHALL be 0 in IDLE, READ, RESP; csr_raddr/csr_waddr/csr_wdata SHALL be 0 when not in use.
REQ-018 req_valid while not in IDLE SHALL be ignored (not captured, not dropped from upstream's view since req_ready=0).

Reset
REQ-019 On reset=1 at clk edge SHALL go to IDLE, clear captured fields, old register, resp_rdata, resp_illegal; resp_valid=0, csr_we=0, req_ready=1 next cycle; reset in WRITE SHALL suppress that cycle's csr_we registered output beyond the reset edge; an in-flight op is discarded with no response.

Configuration
REQ-020 Macro CSR_READONLY_EN: when defined, req_csr[11:10]=11 SHALL mark the CSR read-only; any op that would write (per REQ-012) SHALL be illegal (no write, resp_illegal=1, resp_rdata=0), while suppressed-write ops SHALL complete normally with old value.
REQ-021 Without CSR_READONLY_EN, req_csr[11:10] SHALL be ignored and all CSRs writable.

Verification
REQ-022 Preload idx5=0x0000_00F0; CSRRS (010) csr=0x005 rs1idx=3 rs1val=0x0F -> resp_rdata=0xF0, csr_we N+2 wdata=0xFF.
REQ-023 Preload idx5=0xFF; CSRRCI (111) rs1idx=0x03 -> resp_rdata=0xFF, wdata=0xFC; then CSRRS rs1idx=0 -> resp_rdata=0xFC, csr_we never asserted.
REQ-024 CSRRW (001) csr=0x012 rs1val=0xDEADBEEF, resp_ready=0 for 5 cycles -> resp_valid held, resp_rdata stable, req_ready=0, then IDLE one cycle after resp_ready=1.
REQ-025 funct3=100 -> resp_illegal=1, resp_rdata=0, no csr_we; reset asserted in WRITE of a CSRRW -> no response, state IDLE, register unchanged.
REQ-026 With CSR_READONLY_EN: CSRRW csr=0xC01 -> illegal, no write; CSRRS csr=0xC01 rs1idx=0 -> legal, old value returned. Without macro: CSRRW csr=0xC01 writes idx1.

Source files
------------

// File: rtl/csr_access_unit.sv
// Zicsr read-modify-write sequencer: IDLE -> READ -> WRITE -> RESP around a 64-entry CSR file.
// Optional CSR_READONLY_EN: csr[11:10]==2'b11 marks a CSR read-only, and any op that would write it is rejected.
module csr_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [11:0] req_csr,
    input  logic [4:0]  req_rs1idx,
    input  logic [31:0] req_rs1val,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_illegal,
    output logic [5:0]  csr_raddr,
    input  logic [31:0] csr_rdata,
    output logic        csr_we,
    output logic [5:0]  csr_waddr,
    output logic [31:0] csr_wdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state;
    logic [2:0]  f3_q;
    logic [5:0]  idx_q;
    logic [4:0]  rs1idx_q;
    logic [31:0] rs1val_q;
    logic [31:0] old_q;
    logic        illegal_q;
    logic        we_q;
    logic [5:0]  waddr_q;
    logic [31:0] wdata_q;
    logic        ro_q;

`ifdef CSR_READONLY_EN
    logic unused_csr_mid;
    assign unused_csr_mid = ^req_csr[9:6];
`else
    logic unused_csr_hi;
    assign unused_csr_hi = ^req_csr[11:6];
`endif

    logic [31:0] operand;
    logic [31:0] new_val;
    logic        bad_op;
    logic        wants_write;
    logic        illegal;
    logic        do_write;

    always_comb begin
        operand = f3_q[2] ? {27'b0, rs1idx_q} : rs1val_q;
        new_val = csr_rdata;
        case (f3_q[1:0])
            2'b01:   new_val = operand;
            2'b10:   new_val = csr_rdata | operand;
            2'b11:   new_val = csr_rdata & ~operand;
            default: new_val = csr_rdata;
        endcase
        bad_op      = (f3_q[1:0] == 2'b00);
        // Set/clear with rs1=x0 or zimm=0 is a pure read.
        wants_write = !bad_op && ((f3_q[1:0] == 2'b01) || (rs1idx_q != 5'd0));
        illegal     = bad_op || (ro_q && wants_write);
        do_write    = wants_write && !illegal;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            f3_q      <= '0;
            idx_q     <= '0;
            rs1idx_q  <= '0;
            rs1val_q  <= '0;
            ro_q      <= 1'b0;
            old_q     <= '0;
            illegal_q <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    f3_q     <= req_funct3;
                    idx_q    <= req_csr[5:0];
                    rs1idx_q <= req_rs1idx;
                    rs1val_q <= req_rs1val;
`ifdef CSR_READONLY_EN
                    ro_q     <= (req_csr[11:10] == 2'b11);
`else
                    ro_q     <= 1'b0;
`endif
                    state    <= READ;
                end
                READ: begin
                    // The write strobe/data are registered here so WRITE drives them straight from flops.
                    old_q     <= illegal ? 32'd0 : csr_rdata;
                    illegal_q <= illegal;
                    we_q      <= do_write;
                    waddr_q   <= do_write ? idx_q : 6'd0;
                    wdata_q   <= do_write ? new_val : 32'd0;
                    state     <= WRITE;
                end
                WRITE: begin
                    we_q    <= 1'b0;
                    waddr_q <= '0;
                    wdata_q <= '0;
                    state   <= RESP;
                end
                RESP: if (resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready    = (state == IDLE);
    assign resp_valid   = (state == RESP);
    assign resp_rdata   = old_q;
    assign resp_illegal = illegal_q;
    assign csr_raddr    = (state == READ) ? idx_q : 6'd0;
    // Reset held during WRITE must keep the register file untouched in that very cycle.
    assign csr_we       = we_q & ~reset;
    assign csr_waddr    = waddr_q;
    assign csr_wdata    = wdata_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit: behavioural 64-entry CSR file plus hand-computed expectations.
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_csr;
    logic [4:0]  req_rs1idx;
    logic [31:0] req_rs1val;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_illegal;
    logic [5:0]  csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_we;
    logic [5:0]  csr_waddr;
    logic [31:0] csr_wdata;

    csr_access_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_csr(req_csr), .req_rs1idx(req_rs1idx), .req_rs1val(req_rs1val),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_illegal(resp_illegal), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata)
    );

    always #5 clk = ~clk;

    logic [31:0] rf [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    int          cyc = 0, hs_cyc = 0, we_cyc = 0, rv_cyc = 0, we_cnt = 0;
    logic        rv_seen = 1'b0;
    logic [5:0]  last_waddr = '0;
    logic [31:0] last_wdata = '0;

    assign csr_rdata = rf[csr_raddr];

    always @(posedge clk) begin
        if (pl_en) rf[pl_addr] <= pl_data;
        if (csr_we) begin
            rf[csr_waddr] <= csr_wdata;
            we_cnt     <= we_cnt + 1;
            we_cyc     <= cyc;
            last_waddr <= csr_waddr;
            last_wdata <= csr_wdata;
        end
        if (req_valid && req_ready && !reset) begin
            hs_cyc  <= cyc;
            rv_seen <= 1'b0;
        end else if (resp_valid && !rv_seen) begin
            rv_seen <= 1'b1;
            rv_cyc  <= cyc;
        end
        cyc <= cyc + 1;
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issues one op from IDLE; returns at the first negedge with resp_valid high.
    task automatic do_op(input logic [2:0] f3, input logic [11:0] csr, input logic [4:0] ri,
                         input logic [31:0] rv, output logic [31:0] rdata, output logic ill);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = f3; req_csr = csr; req_rs1idx = ri; req_rs1val = rv;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("resp_timeout", {31'b0, resp_valid}, 32'd1);
        rdata = resp_rdata;
        ill   = resp_illegal;
        if (resp_ready) @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd, r0;
        logic        il, saw_resp;
        int          w0;

        reset = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_csr = '0;
        req_rs1idx = '0; req_rs1val = '0; resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_csr_we", {31'b0, csr_we}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_raddr", {26'b0, csr_raddr}, 32'd0);

        // CSRRS: 0xF0 | 0x0F
        preload(6'd5, 32'h0000_00F0);
        w0 = we_cnt;
        do_op(3'b010, 12'h005, 5'd3, 32'h0F, rd, il);
        chk("rs_rdata", rd, 32'hF0);
        chk("rs_illegal", {31'b0, il}, 32'd0);
        chk("rs_we_cnt", we_cnt - w0, 32'd1);
        chk("rs_waddr", {26'b0, last_waddr}, 32'd5);
        chk("rs_wdata", last_wdata, 32'hFF);
        chk("rs_we_lat", we_cyc - hs_cyc, 32'd2);
        chk("rs_rv_lat", rv_cyc - hs_cyc, 32'd3);
        chk("rs_rf5", rf[5], 32'hFF);

        // CSRRCI 0xFF & ~3, then CSRRS with x0 is read-only
        preload(6'd5, 32'hFF);
        w0 = we_cnt;
        do_op(3'b111, 12'h005, 5'd3, 32'hFFFF_FFFF, rd, il);
        chk("rci_rdata", rd, 32'hFF);
        chk("rci_wdata", last_wdata, 32'hFC);
        chk("rci_we_cnt", we_cnt - w0, 32'd1);
        w0 = we_cnt;
        do_op(3'b010, 12'h005, 5'd0, 32'hFFFF_FFFF, rd, il);
        chk("rs0_rdata", rd, 32'hFC);
        chk("rs0_no_we", we_cnt - w0, 32'd0);
        chk("rs0_rf5", rf[5], 32'hFC);

        // CSRRC with register operand: 0xFC & ~0xF0
        do_op(3'b011, 12'h005, 5'd2, 32'hF0, rd, il);
        chk("rc_rdata", rd, 32'hFC);
        chk("rc_rf5", rf[5], 32'h0C);

        // CSRRWI with zimm=0 still writes
        preload(6'd9, 32'hAB);
        w0 = we_cnt;
        do_op(3'b101, 12'h009, 5'd0, 32'h1234, rd, il);
        chk("rwi0_rdata", rd, 32'hAB);
        chk("rwi0_we_cnt", we_cnt - w0, 32'd1);
        chk("rwi0_rf9", rf[9], 32'd0);

        // CSRRW with a stalled consumer; a request offered meanwhile is ignored
        preload(6'd18, 32'h1234_5678);
        preload(6'd19, 32'h0000_0019);
        resp_ready = 1'b0;
        do_op(3'b001, 12'h012, 5'd4, 32'hDEAD_BEEF, r0, il);
        chk("rw_rdata", r0, 32'h1234_5678);
        req_valid = 1'b1; req_funct3 = 3'b001; req_csr = 12'h013; req_rs1val = 32'h5555_5555;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_resp_valid", {31'b0, resp_valid}, 32'd1);
            chk("stall_rdata", resp_rdata, 32'h1234_5678);
            chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("rw_idle_ready", {31'b0, req_ready}, 32'd1);
        chk("rw_idle_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rw_rf18", rf[18], 32'hDEAD_BEEF);
        chk("rw_rf19", rf[19], 32'h0000_0019);

        // Illegal funct3 values
        w0 = we_cnt;
        do_op(3'b100, 12'h005, 5'd3, 32'hFFFF_FFFF, rd, il);
        chk("ill100_flag", {31'b0, il}, 32'd1);
        chk("ill100_rdata", rd, 32'd0);
        do_op(3'b000, 12'h005, 5'd3, 32'hFFFF_FFFF, rd, il);
        chk("ill000_flag", {31'b0, il}, 32'd1);
        chk("ill000_rdata", rd, 32'd0);
        chk("ill_no_we", we_cnt - w0, 32'd0);
        chk("ill_rf5", rf[5], 32'h0C);

        // Reset during WRITE of a CSRRW discards the op
        preload(6'd7, 32'h55);
        w0 = we_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'b001; req_csr = 12'h007; req_rs1idx = 5'd1; req_rs1val = 32'hAA;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("wr_state_we", {31'b0, csr_we}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_wr_we_gated", {31'b0, csr_we}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_wr_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_wr_rdata", resp_rdata, 32'd0);
        saw_resp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) saw_resp = 1'b1;
        end
        chk("rst_wr_no_resp", {31'b0, saw_resp}, 32'd0);
        chk("rst_wr_rf7", rf[7], 32'h55);
        chk("rst_wr_no_we", we_cnt - w0, 32'd0);

        // Read-only CSR window at csr[11:10]==2'b11
        preload(6'd1, 32'h77);
`ifdef CSR_READONLY_EN
        do_op(3'b001, 12'hC01, 5'd2, 32'h1234, rd, il);
        chk("ro_rw_illegal", {31'b0, il}, 32'd1);
        chk("ro_rw_rdata", rd, 32'd0);
        chk("ro_rw_rf1", rf[1], 32'h77);
        do_op(3'b010, 12'hC01, 5'd0, 32'h1234, rd, il);
        chk("ro_rs0_illegal", {31'b0, il}, 32'd0);
        chk("ro_rs0_rdata", rd, 32'h77);
`else
        do_op(3'b001, 12'hC01, 5'd2, 32'h1234, rd, il);
        chk("hi_rw_illegal", {31'b0, il}, 32'd0);
        chk("hi_rw_rdata", rd, 32'h77);
        chk("hi_rw_rf1", rf[1], 32'h1234);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
